logic_gate_unit: RTL and testbench

Parametrised, pipelined N-input, W-bit bitwise logic unit: the multi-channel, multi-width, mode-selectable successor to the single-bit two-input gate cells. Each accepted beat reduces NUM_IN input words with a selectable operation (AND/OR/XOR/BUF, optionally inverted). It can also fold successive results into a running accumulator with a beat counter. Sits between a valid/ready producer and consumer in the datapath; throughput one beat per cycle.

---
 rtl/logic_gate_pkg.sv | 14 +
 rtl/logic_reduce.sv | 40 ++++
 rtl/logic_gate_unit.sv | 122 ++++++++++++
 tb/tb_logic_gate_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared op encodings for the pipelined bitwise logic unit and its reduction tree.
package logic_gate_pkg;

    localparam int OP_W   = 3;
    localparam int OP_INV = 2;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_BUF = 2'b11
    } op_sel_e;

endpackage

// File: rtl/logic_reduce.sv
// Combinational NUM_IN x WIDTH -> WIDTH bitwise reduction; BUF passes channel 0 through.
module logic_reduce #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0] data,
    input  logic [1:0]              sel,
    output logic [WIDTH-1:0]        result
);
    import logic_gate_pkg::*;

    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] xor_s;

    // Fold every channel under each operation in parallel
    always_comb begin
        and_s = data[WIDTH-1:0];
        or_s  = data[WIDTH-1:0];
        xor_s = data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            and_s = and_s & data[k*WIDTH +: WIDTH];
            or_s  = or_s  | data[k*WIDTH +: WIDTH];
            xor_s = xor_s ^ data[k*WIDTH +: WIDTH];
        end
    end

    // Select the reduction requested by the beat
    always_comb begin
        result = data[WIDTH-1:0];
        case (op_sel_e'(sel))
            OP_AND:  result = and_s;
            OP_OR:   result = or_s;
            OP_XOR:  result = xor_s;
            OP_BUF:  result = data[WIDTH-1:0];
            default: result = data[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Two-stage valid/ready bitwise logic unit: stage 1 reduces the channels, stage 2
// folds results into a running accumulator with a saturating beat counter.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [OP_W-1:0]         op,
    input  logic                    acc_en,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        beat_cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              s1_valid_r;
    logic [WIDTH-1:0]  s1_res_r;
    logic [OP_W-1:0]   s1_op_r;
    logic              s1_acc_en_r;
    logic              s1_acc_clr_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [WIDTH-1:0]  acc_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              accept_s;
    logic              s2_load_s;
    logic              restart_s;
    logic [WIDTH-1:0]  red_s;
    logic [WIDTH-1:0]  comb_s;
    logic [WIDTH-1:0]  acc_next_s;
    logic [CNT_W-1:0]  cnt_next_s;

    logic_reduce #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_reduce (
        .data   (in_data),
        .sel    (op[1:0]),
        .result (red_s)
    );

    // Channel 0 is the new result so BUF selects it, i.e. acc is replaced
    logic_reduce #(.WIDTH(WIDTH), .NUM_IN(2)) u_fold (
        .data   ({acc_r, s1_res_r}),
        .sel    (s1_op_r[1:0]),
        .result (comb_s)
    );

    assign in_ready  = !s1_valid_r || !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign s2_load_s = s1_valid_r && (!out_valid_r || out_ready);

    // Next accumulator value and saturating beat count for a stage-2 load
    always_comb begin
        restart_s  = !s1_acc_en_r || s1_acc_clr_r;
        acc_next_s = comb_s;
        cnt_next_s = cnt_r;
        if (restart_s) begin
            acc_next_s = s1_res_r;
            cnt_next_s = CNT_ONE;
        end else if (cnt_r == CNT_MAX) begin
            acc_next_s = comb_s;
            cnt_next_s = cnt_r;
        end else begin
            acc_next_s = comb_s;
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Stage 1: capture the reduced word and beat controls on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s1_res_r     <= '0;
            s1_op_r      <= '0;
            s1_acc_en_r  <= 1'b0;
            s1_acc_clr_r <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r   <= 1'b1;
            s1_res_r     <= red_s;
            s1_op_r      <= op;
            s1_acc_en_r  <= acc_en;
            s1_acc_clr_r <= acc_clr;
        end else if (s2_load_s) begin
            s1_valid_r   <= 1'b0;
        end else begin
            s1_valid_r   <= s1_valid_r;
        end
    end

    // Stage 2: accumulator, counter and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= acc_next_s ^ {WIDTH{s1_op_r[OP_INV]}};
            acc_r       <= acc_next_s;
            cnt_r       <= cnt_next_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign beat_cnt  = cnt_r;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed-vector bench for logic_gate_unit; a second instance with CNT_W=2 shares the inputs.
module tb_logic_gate_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [2:0]  op;
    logic        acc_en;
    logic        acc_clr;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [7:0]  beat_cnt;
    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  out_data2;
    logic [1:0]  beat_cnt2;

    int vectors;
    int miscompares;

    logic_gate_unit #(.WIDTH(8), .NUM_IN(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_cnt(beat_cnt)
    );

    logic_gate_unit #(.WIDTH(8), .NUM_IN(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .beat_cnt(beat_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 32'($urandom());
            op        = 3'($urandom_range(0, 7));
            acc_en    = 1'($urandom_range(0, 1));
            acc_clr   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (out_valid !== 1'b0 || out_data !== 8'h00 || beat_cnt !== 8'h00 ||
                out_valid2 !== 1'b0 || out_data2 !== 8'h00 || beat_cnt2 !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: got v=%b d=%h c=%0d (sat v=%b d=%h c=%0d), want v=0 d=00 c=0",
                         c, out_valid, out_data, beat_cnt, out_valid2, out_data2, beat_cnt2);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got in_ready=%b, want 1", in_ready);
        end
    endtask

    task automatic test_or();
        @(negedge clk);
        in_data   = {8'h80, 8'h04, 8'h02, 8'h01};
        op        = 3'b001;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL or_latency_early: got out_valid=%b one cycle after accept, want 0", out_valid);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h87 || beat_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL or_result: got v=%b d=%h c=%0d, want v=1 d=87 c=1", out_valid, out_data, beat_cnt);
        end
        idle(2);
    endtask

    task automatic test_nand();
        @(negedge clk);
        in_data  = {8'hFF, 8'h0F, 8'hFF, 8'hFF};
        op       = 3'b100;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hF0 || beat_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL nand_result: got v=%b d=%h c=%0d, want v=1 d=f0 c=1", out_valid, out_data, beat_cnt);
        end
        idle(2);
    endtask

    task automatic test_xor_acc();
        logic [31:0] d  [0:2];
        logic [7:0]  ed [0:2];
        logic [7:0]  ec [0:2];
        d[0] = {8'h11, 8'h11, 8'hF0, 8'hFF};   // reduces to 0x0F
        d[1] = {8'h80, 8'h40, 8'h20, 8'h10};   // reduces to 0xF0
        d[2] = {8'h00, 8'h00, 8'h0C, 8'h30};   // reduces to 0x3C
        ed[0] = 8'h0F; ed[1] = 8'hFF; ed[2] = 8'hC3;
        ec[0] = 8'd1;  ec[1] = 8'd2;  ec[2] = 8'd3;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== ed[c-2] || beat_cnt !== ec[c-2]) begin
                    miscompares++;
                    $display("FAIL xor_acc beat %0d: got v=%b d=%h c=%0d, want v=1 d=%h c=%0d",
                             c - 2, out_valid, out_data, beat_cnt, ed[c-2], ec[c-2]);
                end
            end
            if (c < 3) begin
                in_data  = d[c];
                op       = 3'b010;
                acc_en   = 1'b1;
                acc_clr  = (c == 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        idle(2);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_q [0:5];
        int sent;
        int got;
        sent = 0;
        got  = 0;
        for (int i = 0; i < 6; i++) exp_q[i] = 8'h20 + 8'(i);
        @(negedge clk);
        out_ready = 1'b0;
        op        = 3'b011;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = 1'b1;
            in_data  = {8'($urandom()), 8'($urandom()), 8'($urandom()), exp_q[sent]};
            #1;
            if (in_ready) sent++;
            if (c >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp_q[0] || beat_cnt !== 8'd1) begin
                    miscompares++;
                    $display("FAIL bp_hold cycle %0d: got v=%b d=%h c=%0d, want v=1 d=%h c=1",
                             c, out_valid, out_data, beat_cnt, exp_q[0]);
                end
            end
        end
        vectors++;
        if (sent != 2 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: got accepted=%0d in_ready=%b, want accepted=2 in_ready=0", sent, in_ready);
        end
        for (int c = 0; c < 30 && got < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 6) begin
                in_valid = 1'b1;
                in_data  = {8'($urandom()), 8'($urandom()), 8'($urandom()), exp_q[sent]};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                vectors++;
                if (out_data !== exp_q[got]) begin
                    miscompares++;
                    $display("FAIL bp_order result %0d: got %h, want %h", got, out_data, exp_q[got]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        vectors++;
        if (got != 6) begin
            miscompares++;
            $display("FAIL bp_drain: got %0d results, want 6", got);
        end
        idle(2);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_extra: got out_valid=%b after drain, want 0", out_valid);
        end
    endtask

    task automatic test_saturation_reset();
        logic [7:0] ed  [0:4];
        logic [1:0] ec2 [0:4];
        ed[0] = 8'h01; ed[1] = 8'h03; ed[2] = 8'h07; ed[3] = 8'h0F; ed[4] = 8'h1F;
        ec2[0] = 2'd1; ec2[1] = 2'd2; ec2[2] = 2'd3; ec2[3] = 2'd3; ec2[4] = 2'd3;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                vectors++;
                if (out_valid2 !== 1'b1 || out_data2 !== ed[c-2] || beat_cnt2 !== ec2[c-2] ||
                    beat_cnt !== 8'(c - 1)) begin
                    miscompares++;
                    $display("FAIL sat beat %0d: got v=%b d=%h c=%0d (wide c=%0d), want v=1 d=%h c=%0d (wide c=%0d)",
                             c - 2, out_valid2, out_data2, beat_cnt2, beat_cnt, ed[c-2], ec2[c-2], c - 1);
                end
            end
            in_data  = {8'h00, 8'h00, 8'h00, 8'(8'h01 << (c % 5))};
            op       = 3'b001;
            acc_en   = 1'b1;
            acc_clr  = (c == 0);
            in_valid = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || beat_cnt !== 8'd0 || out_data !== 8'h00 ||
            out_valid2 !== 1'b0 || beat_cnt2 !== 2'd0 || out_data2 !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset: got v=%b d=%h c=%0d (sat v=%b d=%h c=%0d), want v=0 d=00 c=0",
                     out_valid, out_data, beat_cnt, out_valid2, out_data2, beat_cnt2);
        end
        in_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        in_data  = 32'hFFFF_FFFF;
        op       = 3'b000;
        acc_en   = 1'b1;
        acc_clr  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || beat_cnt !== 8'd1 ||
            out_data2 !== 8'h00 || beat_cnt2 !== 2'd1) begin
            miscompares++;
            $display("FAIL post_reset_acc: got v=%b d=%h c=%0d (sat d=%h c=%0d), want v=1 d=00 c=1",
                     out_valid, out_data, beat_cnt, out_data2, beat_cnt2);
        end
        idle(2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 32'h0000_0000;
        op          = 3'b000;
        acc_en      = 1'b0;
        acc_clr     = 1'b0;
        out_ready   = 1'b1;
        test_reset();
        test_or();
        test_nand();
        test_xor_acc();
        test_backpressure();
        test_saturation_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
